// File: rtl/dcm_100.sv
// dcm_100: behavioural 100 MHz clock block with six phase-aligned divided outputs and a lock flag
module dcm_100 #(
  parameter int DIV0 = 1,
  parameter int DIV1 = 2,
  parameter int DIV2 = 4,
  parameter int DIV3 = 5,
  parameter int DIV4 = 8,
  parameter int DIV5 = 10,
  parameter int LOCK_CYCLES = 16
) (
  input  logic CLKIN_IN,
  input  logic RST_IN,
  output logic CLKIN_IBUFG_OUT,
  output logic CLKOUT0_OUT,
  output logic CLKOUT1_OUT,
  output logic CLKOUT2_OUT,
  output logic CLKOUT3_OUT,
  output logic CLKOUT4_OUT,
  output logic CLKOUT5_OUT,
  output logic LOCKED_OUT
);
  localparam int DIVS [6] = '{DIV0, DIV1, DIV2, DIV3, DIV4, DIV5};
  logic [7:0] cnt;
  logic       locked, run;
  logic [5:0] co;
  assign CLKIN_IBUFG_OUT = CLKIN_IN;
  assign LOCKED_OUT = locked;
  assign {CLKOUT5_OUT, CLKOUT4_OUT, CLKOUT3_OUT, CLKOUT2_OUT, CLKOUT1_OUT, CLKOUT0_OUT} = co;
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock
    $error("dcm_100: LOCK_CYCLES out of range 1..255");
  end
  // run marks edges after the first locked one, so dividers start at phase 0 together
  always_ff @(posedge CLKIN_IN or negedge RST_IN)
    if (!RST_IN) begin
      cnt    <= '0;
      locked <= 1'b0;
      run    <= 1'b0;
    end else begin
      cnt    <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
      locked <= locked | (cnt == 8'(LOCK_CYCLES - 1));
      run    <= locked;
    end
  for (genvar i = 0; i < 6; i++) begin : g_out
    if (DIVS[i] < 1 || DIVS[i] > 256) begin : g_bad_div
      $error("dcm_100: DIV ratio out of range 1..256");
    end
    if (DIVS[i] == 1) begin : g_pass
      logic en;
      // enable changes only while the clock is low, so the gated output never runts
      always_ff @(negedge CLKIN_IN or negedge RST_IN)
        if (!RST_IN) en <= 1'b0;
        else en <= locked;
      assign co[i] = CLKIN_IN & en;
    end else begin : g_div
      localparam logic [7:0] LAST = 8'(DIVS[i] - 1);
      localparam logic [7:0] HALF = 8'((DIVS[i] + 1) / 2);
      logic [7:0] ph, np;
      logic       q;
      always_comb np = !run ? 8'd0 : (ph == LAST ? 8'd0 : ph + 8'd1);
      always_ff @(posedge CLKIN_IN or negedge RST_IN)
        if (!RST_IN) begin
          ph <= '0;
          q  <= 1'b0;
        end else if (locked) begin
          ph <= np;
          q  <= np < HALF;
        end
      assign co[i] = q;
    end
  end
endmodule

// File: tb/tb_dcm_100.sv
// tb_dcm_100: random reset pulses against an edge-count model of lock and divider waveforms
`timescale 1ns/100ps
module tb_dcm_100;
  logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic ib_a, ib_b, la, lb;
  logic [5:0] oa, ob;
  int k = 0, n_cmp = 0, n_bad = 0;
  int da [6] = '{1, 2, 4, 5, 8, 10};
  int db [6] = '{1, 3, 4, 5, 8, 10};

  always #5 clk = ~clk;

  dcm_100 u_a (
    .CLKIN_IN(clk), .RST_IN(rst_n), .CLKIN_IBUFG_OUT(ib_a),
    .CLKOUT0_OUT(oa[0]), .CLKOUT1_OUT(oa[1]), .CLKOUT2_OUT(oa[2]),
    .CLKOUT3_OUT(oa[3]), .CLKOUT4_OUT(oa[4]), .CLKOUT5_OUT(oa[5]),
    .LOCKED_OUT(la)
  );

  dcm_100 #(.LOCK_CYCLES(1), .DIV1(3)) u_b (
    .CLKIN_IN(clk), .RST_IN(rst_n), .CLKIN_IBUFG_OUT(ib_b),
    .CLKOUT0_OUT(ob[0]), .CLKOUT1_OUT(ob[1]), .CLKOUT2_OUT(ob[2]),
    .CLKOUT3_OUT(ob[3]), .CLKOUT4_OUT(ob[4]), .CLKOUT5_OUT(ob[5]),
    .LOCKED_OUT(lb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // k = CLKIN posedges since reset release; outputs follow from k alone
  function automatic logic [6:0] model(input int kk, input logic ck, input int lc, input int d [6]);
    logic [6:0] r;
    r = '0;
    r[6] = kk >= lc;
    for (int j = 0; j < 6; j++)
      if (kk > lc) r[j] = (d[j] == 1) ? ck : (((kk - lc - 1) % d[j]) < (d[j] + 1) / 2);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else k <= k + 1;

  always begin
    @(clk);
    #1;
    if (!done) begin
      check("dut_a_outputs", {25'd0, la, oa}, {25'd0, model(k, clk, 16, da)});
      check("dut_b_outputs", {25'd0, lb, ob}, {25'd0, model(k, clk, 1, db)});
      check("ibufg", {30'd0, ib_a, ib_b}, {30'd0, clk, clk});
    end
  end

  initial begin
    int a, l;
    #100 rst_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(20, 260)) @(posedge clk);
      a = $urandom_range(2, 4);
      do l = $urandom_range(2, 14); while (((a + l) % 5) < 2);
      #(a) rst_n = 1'b0;
      #1;
      check("reset_async", {16'd0, la, lb, oa, ob}, 32'd0);
      #(l - 1) rst_n = 1'b1;
    end
    repeat (300) @(posedge clk);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcm_100.md
Name: dcm_100

Overview:
- Synthesizable behavioural clock generator that models the 100 MHz board clocking block.
- Takes the 100 MHz board clock (10 ns period) and passes a buffered copy through.
- Produces six phase-aligned divided clocks (CLKOUT0..5) and a LOCKED_OUT flag.
- Sits at the top of the design and feeds the core and peripherals; downstream logic must hold in reset until LOCKED_OUT=1.

Parameters:
- DIV0, 1, divide ratio of CLKOUT0 (1 = pass-through, 100 MHz)
- DIV1, 2, divide ratio of CLKOUT1 (50 MHz)
- DIV2, 4, divide ratio of CLKOUT2 (25 MHz)
- DIV3, 5, divide ratio of CLKOUT3 (20 MHz)
- DIV4, 8, divide ratio of CLKOUT4 (12.5 MHz)
- DIV5, 10, divide ratio of CLKOUT5 (10 MHz)
- LOCK_CYCLES, 16, CLKIN_IN rising edges after reset release until LOCKED_OUT asserts (legal range 1..255)

Ports:
- CLKIN_IN  input  1  input clock, 100 MHz nominal
- RST_IN  input  1  reset, asynchronous, active-low
- CLKIN_IBUFG_OUT  output  1  buffered copy of CLKIN_IN
- CLKOUT0_OUT .. CLKOUT5_OUT  output  1 each  divided clocks, ratio DIVn
- LOCKED_OUT  output  1  1 = all CLKOUTn running and phase-aligned

Behaviour:
- CLKIN_IBUFG_OUT = CLKIN_IN combinationally, at all times, regardless of reset.
- Reset (RST_IN=0, asynchronous): LOCKED_OUT=0, lock counter=0, all phase counters=0, all CLKOUTn_OUT=0, negedge enable=0.
- Reset may assert at any time, including mid-operation; outputs go low immediately with no glitch requirement beyond that.
- Lock counter:
  - 8-bit; after RST_IN rises, it increments on each CLKIN_IN posedge and saturates.
  - LOCKED_OUT is registered and rises on the LOCK_CYCLES-th posedge after release.
  - Once high, LOCKED_OUT stays high until the next reset.
- Divided outputs (DIVn >= 2):
  - Each has an 8-bit phase counter, clocked on CLKIN_IN posedge.
  - It advances only on edges where LOCKED_OUT was already 1 before the edge.
  - The first such edge (posedge LOCK_CYCLES+1) sets phase 0; phase wraps from DIVn-1 to 0.
  - Output register is high for phases 0..ceil(DIVn/2)-1 and low otherwise. Odd ratios therefore have the longer half high; e.g. DIV=5 gives 3 cycles high, 2 low.
- Pass-through outputs (DIVn = 1):
  - A falling-edge register captures LOCKED_OUT into an enable.
  - CLKOUTn_OUT = CLKIN_IN AND enable, which gives no runt pulse.
  - The first high pulse starts at posedge LOCK_CYCLES+1.
- All outputs rise together at posedge LOCK_CYCLES+1 and stay mutually phase-aligned thereafter.
- Before lock, every CLKOUTn_OUT is held at 0.
- Legal DIVn range is 1..256; values outside this range are a configuration error, flagged by an elaboration-time check.
- No combinational path from RST_IN to CLKIN_IBUFG_OUT.

Test Plan:
- Reset hold: CLKIN 10 ns period, RST_IN=0 for 100 ns -> LOCKED_OUT=0, all CLKOUTn=0, CLKIN_IBUFG_OUT toggles with CLKIN_IN.
- Lock timing: release RST_IN at t=100 ns, between edges -> LOCKED_OUT rises at the 16th posedge after release; no CLKOUT activity before the 17th posedge.
- Frequencies after lock, measured over 200 ns -> periods 10/20/40/50/80/100 ns. High times 5/10/20/30/40/50 ns; CLKOUT3 is high 30 ns and low 20 ns.
- Alignment: at posedge 17 all six outputs rise simultaneously. CLKOUT1 and CLKOUT5 rise together again every 100 ns.
- Mid-run reset: pulse RST_IN low for 10 ns while locked -> all outputs 0 and LOCKED_OUT=0 immediately. Relock takes 16 edges and outputs restart phase-aligned.
- Parameter override: LOCK_CYCLES=1, DIV1=3 -> LOCKED_OUT at the 1st posedge; CLKOUT1 period 30 ns, 20 ns high.
